// File: rtl/speed_pkg.sv
// -----------------------------------------------------------------------------
// speed_pkg
// Shared types and constants for the game-speed path. The speed controller
// produces a rate_t and the game clock divider consumes the same type, so both
// sides agree on the encoding: 00 is the fastest tick rate and 11 the slowest.
//
// Contents:
//   rate_t        2-bit rate select
//   RATE_*        named rate values (fastest, slowest, power-on default)
//   req_e         classification of the requests arriving in one cycle
//   rate_next()   saturating one-step move of a rate value
// -----------------------------------------------------------------------------
package speed_pkg;

  typedef logic [1:0] rate_t;

  localparam rate_t RATE_FASTEST = 2'b00;
  localparam rate_t RATE_SLOWEST = 2'b11;
  localparam rate_t RATE_DEFAULT = 2'b10;

  // Requests seen in one cycle. Opposing requests cancel each other.
  typedef enum logic [1:0] {
    REQ_NONE     = 2'b00,
    REQ_FASTER   = 2'b01,
    REQ_SLOWER   = 2'b10,
    REQ_CONFLICT = 2'b11
  } req_e;

  // Moves the rate one step in the requested direction and saturates at the
  // ends, so the rate can never wrap from 00 to 11 or back.
  function automatic rate_t rate_next(input rate_t cur, input req_e req);
    rate_t nxt;
    nxt = cur;
    case (req)
      REQ_FASTER: if (cur != RATE_FASTEST) nxt = cur - 2'd1;
      REQ_SLOWER: if (cur != RATE_SLOWEST) nxt = cur + 2'd1;
      default:    nxt = cur;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// Cleans up one raw mechanical push-button. The raw level is brought into the
// clk domain with a two-flop synchroniser, then only accepted once it has held
// a new value for DEBOUNCE_CYCLES consecutive cycles. A single-cycle pulse is
// produced on an accepted rising level, so holding the button gives exactly
// one pulse and a release/re-press is needed for the next.
//
// Ports:
//   clk_i    system clock
//   rst_i    synchronous active-high reset, clears all state
//   btn_i    raw asynchronous button, high = pressed
//   press_o  one-cycle pulse when a press has been accepted
// -----------------------------------------------------------------------------
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic press_o
);

  // Counter must be able to hold DEBOUNCE_CYCLES-1; keep at least one bit.
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          level_q;
  logic          level_d;
  logic          levelDly_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // The counter only runs while the synchronised input disagrees with the
  // accepted level; any cycle of agreement (a bounce) restarts it from zero.
  always_comb begin
    level_d = level_q;
    count_d = '0;
    if (sync2_q != level_q) begin
      if (count_q == CNT_LAST) begin
        level_d = sync2_q;
        count_d = '0;
      end else begin
        count_d = count_q + 1'b1;
      end
    end
  end

  // Synchroniser, debounce state and the delayed level used for edge detect.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      level_q    <= 1'b0;
      levelDly_q <= 1'b0;
      count_q    <= '0;
    end else begin
      sync1_q    <= btn_i;
      sync2_q    <= sync1_q;
      level_q    <= level_d;
      levelDly_q <= level_q;
      count_q    <= count_d;
    end
  end

  assign press_o = level_q & ~levelDly_q;

endmodule

// File: rtl/speed_ctrl.sv
// -----------------------------------------------------------------------------
// speed_ctrl
// Owns the 2-bit game speed setting that feeds the game clock divider. Two
// debounced push-buttons step the rate faster or slower, and when auto_en is
// high every AUTO_STEP scored points request one automatic faster step. The
// rate saturates at both ends and opposing requests in the same cycle cancel.
//
// Ports:
//   clk           system clock
//   rst           synchronous active-high reset
//   btn_faster    raw button, high = pressed, requests a faster rate
//   btn_slower    raw button, high = pressed, requests a slower rate
//   score_inc     one-cycle pulse per point scored
//   auto_en       level, enables the automatic speed-up
//   clk_rate      registered rate select (00 fastest .. 11 slowest)
//   rate_changed  registered, high in the first cycle clk_rate shows a new value
//   at_fastest    clk_rate is 00
//   at_slowest    clk_rate is 11
// -----------------------------------------------------------------------------
module speed_ctrl
  import speed_pkg::*;
#(
  parameter int    DEBOUNCE_CYCLES = 1_000_000,
  parameter int    AUTO_STEP       = 10,
  parameter rate_t RATE_RST        = RATE_DEFAULT
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  btn_faster,
  input  logic  btn_slower,
  input  logic  score_inc,
  input  logic  auto_en,
  output rate_t clk_rate,
  output logic  rate_changed,
  output logic  at_fastest,
  output logic  at_slowest
);

  localparam int PW = $clog2(AUTO_STEP + 1);
  localparam logic [PW-1:0] POINTS_LIMIT = PW'(AUTO_STEP);

  logic          pressFaster;
  logic          pressSlower;
  logic [PW-1:0] points_q;
  logic [PW-1:0] points_d;
  logic          autoReq;
  req_e          req;
  rate_t         rate_q;
  rate_t         rate_d;
  logic          rateChanged_q;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb_faster (
    .clk_i  (clk),
    .rst_i  (rst),
    .btn_i  (btn_faster),
    .press_o(pressFaster)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb_slower (
    .clk_i  (clk),
    .rst_i  (rst),
    .btn_i  (btn_slower),
    .press_o(pressSlower)
  );

  // Point counter: counts scored points while auto speed-up is enabled. The
  // point that would reach AUTO_STEP clears the counter and raises autoReq in
  // the same cycle. The counter clears even if that request gets cancelled by
  // a simultaneous slower press, so the next auto step needs a full AUTO_STEP.
  always_comb begin
    points_d = points_q;
    autoReq  = 1'b0;
    if (!auto_en) begin
      points_d = '0;
    end else if (score_inc) begin
      if (points_q + 1'b1 == POINTS_LIMIT) begin
        points_d = '0;
        autoReq  = 1'b1;
      end else begin
        points_d = points_q + 1'b1;
      end
    end
  end

  // Classify this cycle's requests, then apply the saturating step.
  always_comb begin
    req = REQ_NONE;
    case ({pressSlower, pressFaster | autoReq})
      2'b01:   req = REQ_FASTER;
      2'b10:   req = REQ_SLOWER;
      2'b11:   req = REQ_CONFLICT;
      default: req = REQ_NONE;
    endcase
    rate_d = rate_next(rate_q, req);
  end

  // Rate register plus a change flag that is only set when the stored value
  // really moves, so saturated or cancelled requests never pulse it.
  always_ff @(posedge clk) begin
    if (rst) begin
      rate_q        <= RATE_RST;
      rateChanged_q <= 1'b0;
      points_q      <= '0;
    end else begin
      rate_q        <= rate_d;
      rateChanged_q <= (rate_d != rate_q);
      points_q      <= points_d;
    end
  end

  assign clk_rate     = rate_q;
  assign rate_changed = rateChanged_q;
  assign at_fastest   = (rate_q == RATE_FASTEST);
  assign at_slowest   = (rate_q == RATE_SLOWEST);

endmodule

// File: tb/tb_speed_ctrl.sv
// -----------------------------------------------------------------------------
// tb_speed_ctrl
// Self-checking bench for speed_ctrl with DEBOUNCE_CYCLES=4, AUTO_STEP=3.
// Each scenario task drives one cycle at a time, pushes the expected
// {clk_rate, rate_changed, at_fastest, at_slowest} for the coming edge onto a
// queue, then pops and compares it 1 ns after that edge.
// -----------------------------------------------------------------------------
module tb_speed_ctrl;
  import speed_pkg::*;

  logic  clk = 1'b0;
  logic  rst;
  logic  btn_faster;
  logic  btn_slower;
  logic  score_inc;
  logic  auto_en;
  rate_t clk_rate;
  logic  rate_changed;
  logic  at_fastest;
  logic  at_slowest;

  int checks = 0;
  int errors = 0;
  logic [4:0] expQ[$];

  speed_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .AUTO_STEP      (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_faster  (btn_faster),
    .btn_slower  (btn_slower),
    .score_inc   (score_inc),
    .auto_en     (auto_en),
    .clk_rate    (clk_rate),
    .rate_changed(rate_changed),
    .at_fastest  (at_fastest),
    .at_slowest  (at_slowest)
  );

  always #5 clk = ~clk;

  // Builds the expected output vector from the rate the bench predicts.
  function automatic logic [4:0] packExp(input rate_t r, input logic chg);
    return {r, chg, (r == 2'b00), (r == 2'b11)};
  endfunction

  // Brings the DUT to a known idle state; no checks here.
  task automatic do_reset();
    rst        = 1'b1;
    btn_faster = 1'b0;
    btn_slower = 1'b0;
    score_inc  = 1'b0;
    auto_en    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [4:0] obs, expv;
    btn_faster = 1'b0;
    btn_slower = 1'b0;
    score_inc  = 1'b0;
    auto_en    = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      rst = (k <= 2);
      expQ.push_back(packExp(2'b10, 1'b0));
      @(posedge clk); #1;
      obs  = {clk_rate, rate_changed, at_fastest, at_slowest};
      expv = expQ.pop_front();
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("[TB] FAIL reset cycle %0d: {rate,chg,fast,slow} got %b expected %b", k, obs, expv);
      end
    end
  endtask

  task automatic test_clean_press();
    logic [4:0] obs, expv;
    rate_t expRate;
    do_reset();
    expRate = 2'b10;
    for (int k = 1; k <= 20; k++) begin
      btn_faster = 1'b1;
      if (k == 7) expRate = 2'b01;
      expQ.push_back(packExp(expRate, k == 7));
      @(posedge clk); #1;
      obs  = {clk_rate, rate_changed, at_fastest, at_slowest};
      expv = expQ.pop_front();
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("[TB] FAIL clean_press cycle %0d: {rate,chg,fast,slow} got %b expected %b", k, obs, expv);
      end
    end
    btn_faster = 1'b0;
  endtask

  task automatic test_bounce_reject();
    logic [4:0] obs, expv;
    do_reset();
    for (int k = 1; k <= 24; k++) begin
      btn_slower = (k <= 12) ? (((k - 1) / 2) % 2 == 0) : 1'b0;
      expQ.push_back(packExp(2'b10, 1'b0));
      @(posedge clk); #1;
      obs  = {clk_rate, rate_changed, at_fastest, at_slowest};
      expv = expQ.pop_front();
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("[TB] FAIL bounce_reject cycle %0d: {rate,chg,fast,slow} got %b expected %b", k, obs, expv);
      end
    end
  endtask

  // Three faster presses from 10, then four slower presses from 00. Each press
  // holds the button for 10 cycles and releases it for 10.
  task automatic test_saturation();
    logic [4:0] obs, expv;
    rate_t expRate;
    logic  chg;
    do_reset();
    expRate = 2'b10;
    for (int p = 0; p < 7; p++) begin
      for (int k = 1; k <= 20; k++) begin
        if (p < 3) begin
          btn_faster = (k <= 10);
          btn_slower = 1'b0;
        end else begin
          btn_faster = 1'b0;
          btn_slower = (k <= 10);
        end
        chg = 1'b0;
        if (k == 7) begin
          if (p < 3 && expRate != 2'b00) begin
            expRate = expRate - 2'd1;
            chg     = 1'b1;
          end else if (p >= 3 && expRate != 2'b11) begin
            expRate = expRate + 2'd1;
            chg     = 1'b1;
          end
        end
        expQ.push_back(packExp(expRate, chg));
        @(posedge clk); #1;
        obs  = {clk_rate, rate_changed, at_fastest, at_slowest};
        expv = expQ.pop_front();
        checks++;
        if (obs !== expv) begin
          errors++;
          $display("[TB] FAIL saturation press %0d cycle %0d: {rate,chg,fast,slow} got %b expected %b", p, k, obs, expv);
        end
      end
    end
  endtask

  // Score pulses every other cycle: the 3rd and 6th pulses each step faster.
  task automatic test_auto_step();
    logic [4:0] obs, expv;
    rate_t expRate;
    do_reset();
    auto_en = 1'b1;
    expRate = 2'b10;
    for (int k = 1; k <= 14; k++) begin
      score_inc = (k <= 12) && (k % 2 == 0);
      if (k == 6)  expRate = 2'b01;
      if (k == 12) expRate = 2'b00;
      expQ.push_back(packExp(expRate, (k == 6) || (k == 12)));
      @(posedge clk); #1;
      obs  = {clk_rate, rate_changed, at_fastest, at_slowest};
      expv = expQ.pop_front();
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("[TB] FAIL auto_step cycle %0d: {rate,chg,fast,slow} got %b expected %b", k, obs, expv);
      end
    end
    score_inc = 1'b0;
    auto_en   = 1'b0;
  endtask

  // The 3rd point lands in the same cycle as the slower press (edge 7), so
  // nothing changes. Then three points step to 01; two more, an auto_en drop
  // (with an ignored point), and three further points step to 00.
  task automatic test_auto_cancel();
    logic [4:0] obs, expv;
    rate_t expRate;
    do_reset();
    expRate = 2'b10;
    for (int k = 1; k <= 32; k++) begin
      btn_slower = (k <= 8);
      auto_en    = !(k == 21 || k == 22);
      score_inc  = (k == 1) || (k == 3) || (k == 7) ||
                   (k == 12) || (k == 14) || (k == 16) ||
                   (k == 18) || (k == 20) || (k == 21) ||
                   (k == 24) || (k == 26) || (k == 28);
      if (k == 16) expRate = 2'b01;
      if (k == 28) expRate = 2'b00;
      expQ.push_back(packExp(expRate, (k == 16) || (k == 28)));
      @(posedge clk); #1;
      obs  = {clk_rate, rate_changed, at_fastest, at_slowest};
      expv = expQ.pop_front();
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("[TB] FAIL auto_cancel cycle %0d: {rate,chg,fast,slow} got %b expected %b", k, obs, expv);
      end
    end
    score_inc = 1'b0;
    auto_en   = 1'b0;
  endtask

  // Phase 0: reset at edge 4 of a faster debounce, button released -> no change.
  // Phase 1: reset at edge 4 with the button still held -> a full debounce
  // restarts after reset, so the rate moves at edge 11.
  task automatic test_reset_mid();
    logic [4:0] obs, expv;
    rate_t expRate;
    for (int ph = 0; ph < 2; ph++) begin
      do_reset();
      expRate = 2'b10;
      for (int k = 1; k <= 20; k++) begin
        if (ph == 0) begin
          btn_faster = (k <= 3);
          rst        = (k == 4) || (k == 5);
        end else begin
          btn_faster = 1'b1;
          rst        = (k == 4);
        end
        if (ph == 1 && k == 11) expRate = 2'b01;
        expQ.push_back(packExp(expRate, ph == 1 && k == 11));
        @(posedge clk); #1;
        obs  = {clk_rate, rate_changed, at_fastest, at_slowest};
        expv = expQ.pop_front();
        checks++;
        if (obs !== expv) begin
          errors++;
          $display("[TB] FAIL reset_mid phase %0d cycle %0d: {rate,chg,fast,slow} got %b expected %b", ph, k, obs, expv);
        end
      end
      rst        = 1'b0;
      btn_faster = 1'b0;
    end
  endtask

  initial begin
    rst        = 1'b1;
    btn_faster = 1'b0;
    btn_slower = 1'b0;
    score_inc  = 1'b0;
    auto_en    = 1'b0;
    #1;
    test_reset();
    test_clean_press();
    test_bounce_reject();
    test_saturation();
    test_auto_step();
    test_auto_cancel();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Guards against a stalled run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
